// File: rtl/prg_dma_loader_if.sv
// Host download port and DMA write port of the PRG/RAW image loader.
// master is the loader's view; slave is the host/target view.
interface prg_dma_loader_if #(
   parameter int AW = 16
) ();
   logic          ioctl_download;
   logic [7:0]    ioctl_index;
   logic          ioctl_wr;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wait;
   logic [AW-1:0] dma_addr;
   logic [7:0]    dma_din;
   logic          dma_we;
   logic          dma_ready;

   modport master (
      input  ioctl_download, ioctl_index, ioctl_wr,
      input  ioctl_addr, ioctl_dout, dma_ready,
      output ioctl_wait, dma_addr, dma_din, dma_we
   );

   modport slave (
      output ioctl_download, ioctl_index, ioctl_wr,
      output ioctl_addr, ioctl_dout, dma_ready,
      input  ioctl_wait, dma_addr, dma_din, dma_we
   );
endinterface

// File: rtl/prg_dma_loader.sv
// Streams a host download into RAM as a PRG (load-address header) or RAW
// image, then patches end pointers with the last written address + 1.
module prg_dma_loader #(
   parameter int            AW       = 16,
   parameter logic [7:0]    IDX_PRG  = 8'h41,
   parameter logic [7:0]    IDX_RAW  = 8'h00,
   parameter logic [AW-1:0] RAM_TOP  = 16'h8000,
   parameter logic [AW-1:0] RAW_LO   = 16'h0400,
   parameter logic [AW-1:0] RAW_HI   = 16'h8000,
   parameter logic [AW-1:0] RAW_OFS  = 16'h8000,
   parameter int            NPTR     = 3,
   parameter logic [AW-1:0] PTR_BASE = 16'h002A
) (
   input  logic           clk,
   input  logic           reset,
   prg_dma_loader_if.master bus,
   output logic [AW-1:0]  load_start,
   output logic [AW-1:0]  load_end,
   output logic           done,
   output logic           trunc,
   output logic           overrun,
   output logic           short_file
);

   typedef enum logic [2:0] {
      IDLE, HDR_LO, HDR_HI, DATA, RAWDATA, PTR, FIN
   } state_t;

   localparam logic [3:0] NWR = 4'(2 * NPTR);

   state_t        state;
   logic          seen;
   logic [AW-1:0] wptr;
   logic [3:0]    ptr_cnt;

   logic          busy;
   logic          raw_hit;
   logic [AW-1:0] raw_addr;
   logic [AW-1:0] hdr;
   logic [AW-1:0] ptr_addr;
   logic [7:0]    ptr_byte;

   // A write accepted this cycle frees the slot for a new request.
   assign busy     = bus.dma_we & ~bus.dma_ready;
   assign raw_hit  = (bus.ioctl_addr >= 25'(RAW_LO)) &&
                     (bus.ioctl_addr <  25'(RAW_HI));
   assign raw_addr = bus.ioctl_addr[AW-1:0] + RAW_OFS;
   assign hdr      = AW'({bus.ioctl_dout, load_start[7:0]});
   assign ptr_addr = PTR_BASE + AW'(ptr_cnt);
   assign ptr_byte = ptr_cnt[0] ? load_end[15:8] : load_end[7:0];

   assign bus.ioctl_wait = bus.dma_we | (state == PTR) | (state == FIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         seen         <= 1'b0;
         wptr         <= '0;
         ptr_cnt      <= '0;
         load_start   <= '0;
         load_end     <= '0;
         done         <= 1'b0;
         trunc        <= 1'b0;
         overrun      <= 1'b0;
         short_file   <= 1'b0;
         bus.dma_addr <= '0;
         bus.dma_din  <= '0;
         bus.dma_we   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!bus.ioctl_download) seen <= 1'b0;
         if (bus.dma_we && bus.dma_ready) bus.dma_we <= 1'b0;

         unique case (state)
            IDLE: begin
               if (bus.ioctl_download && !seen) begin
                  seen       <= 1'b1;
                  trunc      <= 1'b0;
                  overrun    <= 1'b0;
                  short_file <= 1'b0;
                  ptr_cnt    <= '0;
                  if (bus.ioctl_index == IDX_PRG) state <= HDR_LO;
                  else if (bus.ioctl_index == IDX_RAW) state <= RAWDATA;
               end
            end
            HDR_LO: begin
               if (!bus.ioctl_download) begin
                  short_file <= 1'b1;
                  done       <= 1'b1;
                  state      <= FIN;
               end else if (bus.ioctl_wr && bus.ioctl_addr == 25'd0) begin
                  load_start <= AW'(bus.ioctl_dout);
                  state      <= HDR_HI;
               end
            end
            HDR_HI: begin
               if (!bus.ioctl_download) begin
                  short_file <= 1'b1;
                  done       <= 1'b1;
                  state      <= FIN;
               end else if (bus.ioctl_wr && bus.ioctl_addr == 25'd1) begin
                  load_start <= hdr;
                  load_end   <= hdr;
                  wptr       <= hdr;
                  state      <= DATA;
               end
            end
            DATA: begin
               if (bus.ioctl_wr) begin
                  if (busy) begin
                     overrun <= 1'b1;
                  end else if (wptr < RAM_TOP) begin
                     bus.dma_addr <= wptr;
                     bus.dma_din  <= bus.ioctl_dout;
                     bus.dma_we   <= 1'b1;
                     if (wptr != '1) begin
                        wptr     <= wptr + 1'b1;
                        load_end <= load_end + 1'b1;
                     end
                  end else begin
                     trunc <= 1'b1;
                  end
               end else if (!bus.ioctl_download && !busy) begin
                  if (NPTR == 0) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     state <= PTR;
                  end
               end
            end
            RAWDATA: begin
               if (bus.ioctl_wr) begin
                  if (busy) begin
                     overrun <= 1'b1;
                  end else if (raw_hit) begin
                     bus.dma_addr <= raw_addr;
                     bus.dma_din  <= bus.ioctl_dout;
                     bus.dma_we   <= 1'b1;
                  end
               end else if (!bus.ioctl_download && !busy) begin
                  done  <= 1'b1;
                  state <= FIN;
               end
            end
            PTR: begin
               if (!busy) begin
                  if (ptr_cnt == NWR) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     bus.dma_addr <= ptr_addr;
                     bus.dma_din  <= ptr_byte;
                     bus.dma_we   <= 1'b1;
                     ptr_cnt      <= ptr_cnt + 1'b1;
                  end
               end
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prg_dma_loader.sv
// Bench for prg_dma_loader: directed table, stall/reset sequences and
// randomized loads checked against a file-level reference model.
module tb_prg_dma_loader;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   typedef struct packed {
      bit               prg;
      logic [3:0]       n;
      logic [0:5][7:0]  b;
      logic [0:5][15:0] a;
      logic [7:0]       nwr;
      logic [15:0]      last_a;
      logic [7:0]       last_d;
      bit               trunc;
      bit               shrt;
      bit               chk_end;
      logic [15:0]      endv;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [15:0] load_start, load_end;
   logic        done, trunc, overrun, short_file;

   prg_dma_loader_if #(.AW(16)) bus ();

   prg_dma_loader dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .load_start (load_start),
      .load_end   (load_end),
      .done       (done),
      .trunc      (trunc),
      .overrun    (overrun),
      .short_file (short_file)
   );

   int n_pass = 0;
   int n_chk  = 0;

   bit   rdy_rand = 0;
   logic rdy_val  = 1;
   logic rnd_bit  = 0;
   assign bus.dma_ready = rdy_rand ? rnd_bit : rdy_val;

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

   wr_t got_q[$];
   int  done_cnt   = 0;
   int  we_cycles  = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.dma_we) we_cycles <= we_cycles + 1;
         if (bus.dma_we && bus.dma_ready)
            got_q.push_back({bus.dma_addr, bus.dma_din});
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   logic [7:0]  file_q[$];
   logic [24:0] addr_q[$];
   wr_t         exp_q[$];
   bit          exp_trunc, exp_short;
   int          exp_end;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference: what the file means, in plain arithmetic.
   task automatic model(input bit prg);
      int p;
      exp_q.delete();
      exp_trunc = 0;
      exp_short = 0;
      if (prg) begin
         if (file_q.size() < 2) begin
            exp_short = 1;
         end else begin
            p = int'(file_q[0]) + 256 * int'(file_q[1]);
            for (int i = 2; i < file_q.size(); i++) begin
               if (p < 'h8000) begin
                  exp_q.push_back({16'(p), file_q[i]});
                  p++;
               end else begin
                  exp_trunc = 1;
               end
            end
            for (int k = 0; k < 3; k++) begin
               exp_q.push_back({16'('h2A + 2 * k), 8'(p % 256)});
               exp_q.push_back({16'('h2B + 2 * k), 8'(p / 256)});
            end
            exp_end = p;
         end
      end else begin
         foreach (file_q[i]) begin
            if (addr_q[i] >= 25'h400 && addr_q[i] < 25'h8000)
               exp_q.push_back({16'(addr_q[i] + 25'h8000), file_q[i]});
         end
      end
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      for (int k = 0; k < 100 && bus.ioctl_wait; k++) tick();
      if (bus.ioctl_wait) chk("ioctl_wait_timeout", 1, 0);
      bus.ioctl_wr   = 1;
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      tick();
      bus.ioctl_wr = 0;
   endtask

   task automatic run_load(input logic [7:0] idx);
      bus.ioctl_index    = idx;
      bus.ioctl_download = 1;
      tick();
      foreach (file_q[i]) send_byte(addr_q[i], file_q[i]);
      bus.ioctl_download = 0;
   endtask

   task automatic wait_done(input int d0);
      for (int k = 0; k < 400 && done_cnt == d0; k++) tick();
      repeat (3) tick();
      chk("done_pulses", done_cnt - d0, 1);
   endtask

   task automatic cmp_writes(input string nm, input int base);
      int n;
      n = got_q.size() - base;
      chk({nm, "_nwr"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         chk({nm, "_wr"}, got_q[base + i], exp_q[i]);
   endtask

   task automatic cmp_flags(input string nm, input bit prg);
      chk({nm, "_trunc"}, trunc, exp_trunc);
      chk({nm, "_short"}, short_file, exp_short);
      if (prg && !exp_short) chk({nm, "_end"}, load_end, exp_end);
   endtask

   vec_t vecs[5];

   initial begin
      int base, d0, w0;
      vec_t v;

      vecs[0] = '{prg: 1'b1, n: 4'd5,
         b: {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'h00},
         a: {16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5},
         nwr: 8'd9, last_a: 16'h002F, last_d: 8'h04,
         trunc: 1'b0, shrt: 1'b0, chk_end: 1'b1, endv: 16'h0404};
      vecs[1] = '{prg: 1'b1, n: 4'd6,
         b: {8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44},
         a: {16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5},
         nwr: 8'd8, last_a: 16'h002F, last_d: 8'h80,
         trunc: 1'b1, shrt: 1'b0, chk_end: 1'b1, endv: 16'h8000};
      vecs[2] = '{prg: 1'b0, n: 4'd4,
         b: {8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00},
         a: {16'h03FF, 16'h0400, 16'h7FFF, 16'h8000, 16'h0, 16'h0},
         nwr: 8'd2, last_a: 16'hFFFF, last_d: 8'h33,
         trunc: 1'b0, shrt: 1'b0, chk_end: 1'b0, endv: 16'h0};
      vecs[3] = '{prg: 1'b1, n: 4'd1,
         b: {8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
         a: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
         nwr: 8'd0, last_a: 16'h0, last_d: 8'h0,
         trunc: 1'b0, shrt: 1'b1, chk_end: 1'b0, endv: 16'h0};
      vecs[4] = '{prg: 1'b1, n: 4'd2,
         b: {8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00},
         a: {16'h0, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0},
         nwr: 8'd6, last_a: 16'h002F, last_d: 8'h10,
         trunc: 1'b0, shrt: 1'b0, chk_end: 1'b1, endv: 16'h1000};

      reset = 1;
      bus.ioctl_download = 0;
      bus.ioctl_index    = 0;
      bus.ioctl_wr       = 0;
      bus.ioctl_addr     = 0;
      bus.ioctl_dout     = 0;
      repeat (3) tick();
      reset = 0;
      tick();
      chk("rst_we", bus.dma_we, 0);
      chk("rst_wait", bus.ioctl_wait, 0);
      chk("rst_addr", bus.dma_addr, 0);
      chk("rst_din", bus.dma_din, 0);
      chk("rst_done", done, 0);
      chk("rst_flags", {trunc, overrun, short_file}, 0);
      chk("rst_start", load_start, 0);
      chk("rst_end", load_end, 0);

      // Unknown index: no writes, no done.
      base = got_q.size();
      d0   = done_cnt;
      file_q = '{8'h00, 8'h20, 8'h99};
      addr_q = '{25'd0, 25'd1, 25'd2};
      run_load(8'h55);
      repeat (10) tick();
      chk("badidx_nwr", got_q.size() - base, 0);
      chk("badidx_done", done_cnt - d0, 0);

      for (int t = 0; t < 5; t++) begin
         v = vecs[t];
         file_q.delete();
         addr_q.delete();
         for (int i = 0; i < int'(v.n); i++) begin
            file_q.push_back(v.b[i]);
            addr_q.push_back(v.prg ? 25'(i) : 25'(v.a[i]));
         end
         model(v.prg);
         base = got_q.size();
         d0   = done_cnt;
         w0   = we_cycles;
         run_load(v.prg ? 8'h41 : 8'h00);
         wait_done(d0);
         cmp_writes("tbl_model", base);
         chk("tbl_nwr", got_q.size() - base, v.nwr);
         if (v.nwr != 0 && got_q.size() > base) begin
            chk("tbl_last_a", got_q[got_q.size() - 1].a, v.last_a);
            chk("tbl_last_d", got_q[got_q.size() - 1].d, v.last_d);
         end
         if (v.nwr == 0) chk("tbl_we_cycles", we_cycles - w0, 0);
         chk("tbl_trunc", trunc, v.trunc);
         chk("tbl_short", short_file, v.shrt);
         chk("tbl_overrun", overrun, 0);
         if (v.chk_end) chk("tbl_end", load_end, v.endv);
      end

      // Target stalls the first data byte; a stray strobe must be dropped.
      rdy_val = 0;
      base = got_q.size();
      d0   = done_cnt;
      file_q = '{8'h00, 8'h20, 8'h5A};
      addr_q = '{25'd0, 25'd1, 25'd2};
      model(1);
      bus.ioctl_index    = 8'h41;
      bus.ioctl_download = 1;
      tick();
      foreach (file_q[i]) send_byte(addr_q[i], file_q[i]);
      for (int i = 0; i < 5; i++) begin
         chk("stall_we", bus.dma_we, 1);
         chk("stall_addr", bus.dma_addr, 16'h2000);
         chk("stall_din", bus.dma_din, 8'h5A);
         chk("stall_wait", bus.ioctl_wait, 1);
         bus.ioctl_wr   = (i == 1);
         bus.ioctl_addr = 25'd3;
         bus.ioctl_dout = 8'h77;
         tick();
      end
      bus.ioctl_wr = 0;
      chk("stall_overrun", overrun, 1);
      rdy_val = 1;
      bus.ioctl_download = 0;
      wait_done(d0);
      cmp_writes("stall", base);
      chk("stall_overrun_sticky", overrun, 1);

      // Reset lands right after the second pointer write is accepted.
      base = got_q.size();
      d0   = done_cnt;
      file_q = '{8'h00, 8'h30, 8'h99};
      addr_q = '{25'd0, 25'd1, 25'd2};
      run_load(8'h41);
      for (int k = 0; k < 100 && got_q.size() - base < 3; k++) tick();
      chk("rst_mid_reach", got_q.size() - base, 3);
      reset = 1;
      tick();
      chk("rst_mid_we", bus.dma_we, 0);
      tick();
      reset = 0;
      repeat (20) tick();
      chk("rst_mid_nwr", got_q.size() - base, 3);
      chk("rst_mid_done", done_cnt - d0, 0);
      chk("rst_mid_end", load_end, 0);
      chk("rst_mid_wait", bus.ioctl_wait, 0);

      rdy_rand = 1;
      for (int r = 0; r < 12; r++) begin
         bit prg;
         int st, nd;
         prg = 1'($urandom_range(0, 1));
         file_q.delete();
         addr_q.delete();
         if (prg) begin
            if ($urandom_range(0, 7) == 0) begin
               nd = $urandom_range(0, 1);
               for (int i = 0; i < nd; i++)
                  file_q.push_back(8'($urandom_range(0, 255)));
            end else begin
               st = $urandom_range(0, 1) ? $urandom_range('h400, 'h7FF0)
                                         : $urandom_range('h7FF8, 'h7FFF);
               file_q.push_back(8'(st % 256));
               file_q.push_back(8'(st / 256));
               nd = $urandom_range(0, 12);
               for (int i = 0; i < nd; i++)
                  file_q.push_back(8'($urandom_range(0, 255)));
            end
            foreach (file_q[i]) addr_q.push_back(25'(i));
         end else begin
            nd = $urandom_range(1, 10);
            for (int i = 0; i < nd; i++) begin
               case ($urandom_range(0, 5))
                  0: addr_q.push_back(25'h3FF);
                  1: addr_q.push_back(25'h400);
                  2: addr_q.push_back(25'h7FFF);
                  3: addr_q.push_back(25'h8000);
                  4: addr_q.push_back(25'($urandom_range(0, 'h1FFFFFF)));
                  default: addr_q.push_back(25'($urandom_range(0, 'hFFFF)));
               endcase
               file_q.push_back(8'($urandom_range(0, 255)));
            end
         end
         model(prg);
         base = got_q.size();
         d0   = done_cnt;
         run_load(prg ? 8'h41 : 8'h00);
         wait_done(d0);
         cmp_writes("rnd", base);
         cmp_flags("rnd", prg);
         chk("rnd_overrun", overrun, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/prg_dma_loader.md
PRG_DMA_LOADER -- requirements
Module: prg_dma_loader

Interface
REQ-001 Parameter AW, 16, width of the target address bus.
REQ-002 Parameter IDX_PRG, 8'h41, ioctl_index value that selects PRG mode (2-byte little-endian load-address header).
REQ-003 Parameter IDX_RAW, 8'h00, ioctl_index value that selects RAW mode (headerless image).
REQ-004 Parameter RAM_TOP, 16'h8000, first address above writable RAM in PRG mode.
REQ-005 Parameter RAW_LO, 16'h0400; RAW_HI, 16'h8000, accepted ioctl_addr window [RAW_LO,RAW_HI) in RAW mode.
REQ-006 Parameter RAW_OFS, 16'h8000, added modulo 2^AW to ioctl_addr[AW-1:0] in RAW mode.
REQ-007 Parameter NPTR, 3 (range 0..4), number of 2-byte end pointers written after a PRG load.
REQ-008 Parameter PTR_BASE, 16'h002A, address of the first end pointer; pointer k occupies PTR_BASE+2k (lo) and PTR_BASE+2k+1 (hi).
REQ-009 clk  in  1  system clock; all logic on rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 ioctl_download  in  1  high for the duration of a host transfer.
REQ-012 ioctl_index  in  8  transfer type; sampled while ioctl_download=1.
REQ-013 ioctl_wr  in  1  one-cycle byte strobe.
REQ-014 ioctl_addr  in  25  byte offset within the file.
REQ-015 ioctl_dout  in  8  byte value.
REQ-016 ioctl_wait  out  1  host stall request.
REQ-017 dma_addr  out  AW  target address.
REQ-018 dma_din  out  8  target data.
REQ-019 dma_we  out  1  write request; held until accepted.
REQ-020 dma_ready  in  1  target accepts the write in any cycle where dma_we=1 and dma_ready=1.
REQ-021 load_start, load_end  out  AW each  PRG header address, and last written address+1.
REQ-022 done  out  1  one-cycle pulse when a load (including pointer writes) completes.
REQ-023 trunc, overrun, short_file  out  1 each  sticky error flags, cleared at the start of the next download.

Function
REQ-024 States: IDLE, HDR_LO, HDR_HI, DATA, RAWDATA, PTR, FIN.
- IDLE->HDR_LO on ioctl_download rising with ioctl_index=IDX_PRG.
- IDLE->RAWDATA on ioctl_download rising with ioctl_index=IDX_RAW.
- Any other index: stay in IDLE, no writes.
REQ-025 HDR_LO: byte at ioctl_addr 0 -> load_start[7:0]; then HDR_HI.
REQ-026 HDR_HI: byte at ioctl_addr 1 -> load_start[15:8] (upper AW bits zero); the write pointer is set to load_start and load_end to load_start; then DATA.
REQ-027 DATA: each ioctl_wr issues a write at the write pointer if pointer<RAM_TOP; pointer and load_end then increment. If pointer>=RAM_TOP, the byte is dropped and trunc=1; the pointer does not wrap past 2^AW-1.
REQ-028 RAWDATA: each ioctl_wr with RAW_LO<=ioctl_addr<RAW_HI writes dma_addr=ioctl_addr+RAW_OFS; bytes outside the window are silently dropped.
REQ-029 Handshake: dma_addr, dma_din and dma_we stay stable from request until the accept cycle. dma_we deasserts the cycle after accept unless a new request is loaded. ioctl_wait=1 whenever a write is pending, and during PTR and FIN.
REQ-030 An ioctl_wr that arrives while a write is pending drops the byte and sets overrun=1; the pending write is unaffected.
REQ-031 PRG end: on ioctl_download falling with the header complete -> PTR. The block writes load_end lo and hi to each of the NPTR pointers in ascending address order, 2*NPTR writes, each through the REQ-029 handshake. Then FIN.
REQ-032 NPTR=0: PTR is skipped.
REQ-033 PRG end before the header is complete (fewer than 2 bytes): short_file=1, no pointer writes, -> FIN.
REQ-034 RAW end: on ioctl_download falling -> FIN.
REQ-035 FIN: done=1 for one cycle, then IDLE. The final pending write must be accepted before FIN.
REQ-036 ioctl_download rising during PTR or FIN is held off: the new load starts from IDLE only after FIN.

Reset
REQ-037 Reset values:
- State IDLE.
- dma_we, ioctl_wait, done, trunc, overrun, short_file = 0.
- dma_addr, dma_din, load_start, load_end = 0.
REQ-038 Reset mid-operation cancels any pending write and any remaining pointer writes in the same cycle; no further dma_we is issued until a new download.

Verification
REQ-039 PRG file 01 04 AA BB CC, dma_ready=1 -> writes 0401=AA, 0402=BB, 0403=CC; then 002A=04, 002B=04, 002C=04, 002D=04, 002E=04, 002F=04; load_end=0404; done pulses once.
REQ-040 PRG header FE 7F followed by 4 bytes -> writes only to 7FFE and 7FFF; trunc=1; pointers hold 8000.
REQ-041 RAW mode, bytes at ioctl_addr 03FF, 0400, 7FFF, 8000 -> exactly two writes, to 8400 and FFFF.
REQ-042 dma_ready held low 5 cycles on the first data byte -> dma_addr/dma_din/dma_we stable and ioctl_wait=1 throughout; a strobe injected during the stall sets overrun=1.
REQ-043 One-byte PRG file -> short_file=1, zero dma_we cycles, done pulses.
REQ-044 reset asserted after the second pointer write is accepted -> dma_we=0 the following cycle; no further writes; done is not pulsed.
